// File: rtl/decode_stage.sv
// Pipelined instruction decode stage: one-entry stage register, decoder, integer
// register file and a pending-write scoreboard that stalls on RAW/WAW hazards.
module decode_stage #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_rd_write,
    output logic            out_use_imm,
    output logic            out_illegal,
    output logic [1:0]      out_branch,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);
    localparam int RW = $clog2(NREGS);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic [1:0] BR_NONE  = 2'd0;
    localparam logic [1:0] BR_TRUE  = 2'd1;
    localparam logic [1:0] BR_FALSE = 2'd2;

    logic            d_valid;
    logic [31:0]     d_instr;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pending, pend_set, pend_clr, pend_eff;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic       known, writes, uses_rs1, uses_rs2, bad_f3, reg_bad, illegal, rd_write;
    logic       hazard, fire, wb_hit;
    logic [1:0] branch;
    logic [XLEN-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = d_instr[6:0];
    assign funct3 = d_instr[14:12];
    assign rd     = d_instr[11:7];
    assign rs1    = d_instr[19:15];
    assign rs2    = d_instr[24:20];

    assign imm_i = {{(XLEN-12){d_instr[31]}}, d_instr[31:20]};
    assign imm_s = {{(XLEN-12){d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
    assign imm_b = {{(XLEN-13){d_instr[31]}}, d_instr[31], d_instr[7], d_instr[30:25],
                    d_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){d_instr[31]}}, d_instr[31:12], 12'd0};
    assign imm_j = {{(XLEN-21){d_instr[31]}}, d_instr[31], d_instr[19:12], d_instr[20],
                    d_instr[30:21], 1'b0};

    always_comb begin
        known    = 1'b0;
        writes   = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        bad_f3   = 1'b0;
        branch   = BR_NONE;
        imm      = '0;
        case (opcode)
            OPC_OP: begin
                known = 1'b1; writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                known = 1'b1; writes = 1'b1; uses_rs1 = 1'b1; imm = imm_i;
            end
            OPC_STORE: begin
                known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_s;
            end
            OPC_BRANCH: begin
                known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_b;
                case (funct3)
                    3'b000, 3'b100, 3'b110: branch = BR_TRUE;
                    3'b001, 3'b101, 3'b111: branch = BR_FALSE;
                    default:                bad_f3 = 1'b1;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                known = 1'b1; writes = 1'b1; imm = imm_u;
            end
            OPC_JAL: begin
                known = 1'b1; writes = 1'b1; imm = imm_j;
            end
            default: ;
        endcase
    end

    // Reduced register files reject any referenced index beyond x15.
    assign reg_bad  = (NREGS == 16) && ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) ||
                                        (writes && rd[4]));
    assign illegal  = !known || bad_f3 || reg_bad;
    assign rd_write = writes && (rd != 5'd0) && !illegal;

    assign wb_hit = wb_valid && ({27'd0, wb_rd} < 32'(NREGS));

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (fire && !flush && rd_write) pend_set[rd[RW-1:0]] = 1'b1;
        if (wb_hit) pend_clr[wb_rd[RW-1:0]] = 1'b1;
    end

    // With bypass the retiring writeback releases its consumer in the same cycle.
    assign pend_eff = BYPASS ? (pending & ~pend_clr) : pending;

    assign hazard = !illegal && ((uses_rs1 && pend_eff[rs1[RW-1:0]]) ||
                                 (uses_rs2 && pend_eff[rs2[RW-1:0]]) ||
                                 (rd_write && pend_eff[rd[RW-1:0]]));

    assign out_valid = d_valid && !hazard;
    assign fire      = out_valid && out_ready;
    assign in_ready  = !flush && (!d_valid || fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_instr <= '0;
        end else if (in_valid && in_ready) begin
            d_valid <= 1'b1;
            d_instr <= in_instr;
        end else if (fire || flush) begin
            d_valid <= 1'b0;
        end
    end

    // Set beats clear when the same register retires and reissues together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~pend_clr) | pend_set) & {{(NREGS-1){1'b1}}, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_hit && (wb_rd != 5'd0)) begin
            regs[wb_rd[RW-1:0]] <= wb_data;
        end
    end

    always_comb begin
        out_rs1_data = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
        out_rs2_data = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];
        if (BYPASS && wb_valid && (wb_rd == rs1) && (rs1 != 5'd0)) out_rs1_data = wb_data;
        if (BYPASS && wb_valid && (wb_rd == rs2) && (rs2 != 5'd0)) out_rs2_data = wb_data;
    end

    assign out_rd_write = rd_write;
    assign out_use_imm  = (opcode != OPC_OP) && (opcode != OPC_BRANCH);
    assign out_illegal  = illegal;
    assign out_branch   = branch;
    assign out_opcode   = opcode;
    assign out_funct3   = funct3;
    assign out_funct7   = d_instr[31:25];
    assign out_rs1      = rs1;
    assign out_rs2      = rs2;
    assign out_rd       = rd;
    assign out_imm      = imm;
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined successor to the combinational decode path. Holds one instruction in a stage register behind a valid/ready handshake. Decodes control, immediate and register operands; owns the integer register file. Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards until the matching writeback arrives. Sits between fetch (upstream) and execute (downstream).

## Interface

- XLEN, 64, datapath width; 32 or 64; immediates sign-extend to XLEN.
- NREGS, 32, architectural register count; 32 or 16 (RV32E-style).
- BYPASS, 1, 1 = writeback data forwarded to same-cycle operand reads; 0 = regfile read only.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  32  raw instruction.
- out_valid  out  1  decoded instruction ready for execute.
- out_ready  in  1  execute accepts.
- out_rd_write, out_use_imm, out_illegal  out  1 each  control flags.
- out_branch  out  2  0 NONE, 1 TRUE, 2 FALSE.
- out_opcode, out_funct3, out_funct7  out  7/3/7  pass-through fields.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_rs1_data, out_rs2_data, out_imm  out  XLEN each  operands, immediate.
- wb_valid  in  1  writeback strobe.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback value.
- flush  in  1  discard instruction held in stage.

## Operation

- Stage register: d_valid, d_instr. fire = out_valid && out_ready. in_ready = !flush && (!d_valid || fire). Load d_instr and set d_valid on in_valid && in_ready. Otherwise clear d_valid on fire or flush.
- Outputs are combinational from d_instr. out_valid = d_valid && !hazard.
- Opcodes: OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR. Anything else: out_illegal=1, out_rd_write=0, out_branch=NONE.
- out_illegal is also set when NREGS=16 and any used register index has bit 4 set, and for BRANCH with funct3 010/011.
- out_rd_write: OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR; forced 0 when rd=x0 or illegal.
- out_use_imm: every opcode except OP and BRANCH.
- out_branch: non-BRANCH gives NONE; funct3 000/100/110 gives TRUE; 001/101/111 gives FALSE.
- Immediate formats: I (OP_IMM, LOAD, JALR), S, B, U, J. All sign-extended from instr[31] to XLEN. U-type is instr[31:12]<<12. Unused formats yield 0.
- uses_rs1: OP, OP_IMM, LOAD, STORE, BRANCH, JALR. uses_rs2: OP, STORE, BRANCH.
- Register file: NREGS x XLEN. x0 reads 0; writes to x0 are ignored. Written on wb_valid.
- Operand read with BYPASS=1: if wb_valid && wb_rd==rs && rs!=0, return wb_data.
- Scoreboard: one pending bit per register; bit 0 is always 0.
  - Set on fire when out_rd_write.
  - Cleared on wb_valid for wb_rd.
  - Same register set and cleared in one cycle: set wins.
- hazard: (uses_rs1 && pending[rs1]) || (uses_rs2 && pending[rs2]) || (out_rd_write && pending[rd]).
  - With BYPASS=1, a pending bit being cleared by this cycle's writeback counts as not pending.
  - With BYPASS=0, the stall lasts until the cycle after the writeback.
- Illegal instructions never stall on hazards and never set the scoreboard.
- flush does not touch the scoreboard or the register file.

## Timing

- Reset (async assert, sync release):
  - d_valid=0, all pending bits=0, registers=0.
  - Hence out_valid=0, in_ready=1, all data outputs 0 (d_instr reset to 0).
- Latency: accepted in cycle N, out_valid earliest in cycle N+1.
- Full throughput: one instruction per cycle when there are no hazards and out_ready=1.
- Handshake: once out_valid=1, outputs stay stable until fire or flush. out_valid may fall only on flush.
- A hazard that clears raises out_valid in the same cycle (BYPASS=1) or the next cycle (BYPASS=0).
- flush and in_valid in the same cycle: instruction is not accepted; d_valid=0 next cycle.
- flush and fire in the same cycle: fire is suppressed; no scoreboard set.

## Test plan

- Reset mid-stream with d_valid=1 and pending[5]=1 -> out_valid=0 and in_ready=1 immediately; after release, "addi x5,x0,1" issues with no stall.
- "addi x1,x0,-1" (XLEN=64) -> out_imm=0xFFFF_FFFF_FFFF_FFFF, out_use_imm=1, out_rd_write=1, out_rd=1, and pending[1] set after fire.
- "addi x1" then "add x2,x1,x1" back-to-back -> add stalls (out_valid=0).
  - wb_valid, wb_rd=1, wb_data=7 with BYPASS=1 -> same cycle out_valid=1, rs1_data=rs2_data=7.
  - Same with BYPASS=0 -> out_valid rises one cycle later.
- "bne x3,x4,-8" -> out_branch=FALSE, out_imm=-8, out_rd_write=0, no scoreboard change.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0. flush -> out_valid=0 next cycle, scoreboard unchanged.
- NREGS=16, "add x17,x1,x2" -> out_illegal=1, out_rd_write=0, no stall. Opcode 0x7F -> out_illegal=1.
